// File: rtl/des_sbox_pkg.sv
// Shared constants and types for the DES substitution layer: the eight FIPS 46-3
// S-box tables, the controller state encoding and the LANES legality check.
package des_sbox_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Indexed by {row, col}: row = {b1, b6}, col = b2..b5 of the 6-bit chunk.
    localparam logic [3:0] SBOX [0:7][0:63] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
    };

    function automatic bit lanes_legal(input int n);
        return (n == 1) || (n == 2) || (n == 4) || (n == 8);
    endfunction

endpackage

// File: rtl/des_sbox_rom.sv
// Single DES S-box lookup: selects one of S1..S8 and remaps the 6-bit chunk
// into the {row, col} table index.
module des_sbox_rom
    import des_sbox_pkg::*;
(
    input  logic [2:0] sel,
    input  logic [5:0] addr,
    output logic [3:0] dout
);

    assign dout = SBOX[sel][{addr[5], addr[0], addr[4:1]}];

endmodule

// File: rtl/des_sbox_layer_seq.sv
// Iterative DES substitution layer: evaluates LANES S-boxes per cycle over
// 8/LANES RUN cycles, with valid/ready handshakes on input and output.
module des_sbox_layer_seq
    import des_sbox_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam int NGRP = 8 / LANES;

    if (!lanes_legal(LANES)) begin : g_bad_lanes
        $error("des_sbox_layer_seq: LANES must be 1, 2, 4 or 8");
    end

    state_t      state;
    logic [2:0]  grp;
    logic [47:0] src_reg;
    logic [31:0] res_reg;
    logic [31:0] res_next;
    logic [5:0]  chunk [0:7];
    logic [3:0]  nib   [0:LANES-1];

    for (genvar s = 0; s < 8; s++) begin : g_chunk
        assign chunk[s] = src_reg[47-6*s -: 6];
    end

    // Lane l of group grp handles S-box grp*LANES + l.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [2:0] sel;
        assign sel = 3'(int'(grp) * LANES + l);
        des_sbox_rom u_rom (
            .sel  (sel),
            .addr (chunk[sel]),
            .dout (nib[l])
        );
    end

    always_comb begin
        res_next = res_reg;
        for (int s = 0; s < 8; s++) begin
            if (int'(grp) == s / LANES)
                res_next[31-4*s -: 4] = nib[s % LANES];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grp     <= '0;
            src_reg <= '0;
            res_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        src_reg <= in_data;
                        res_reg <= '0;
                        grp     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    res_reg <= res_next;
                    if (int'(grp) == NGRP - 1) begin
                        grp   <= '0;
                        state <= DONE;
                    end else begin
                        grp <= grp + 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = res_reg;

endmodule

// File: doc/des_sbox_layer_seq.md
Name: des_sbox_layer_seq

Overview:
- Full DES substitution layer (S1..S8) as one sequential unit, with a valid/ready handshake on both sides.
- Maps a 48-bit post-expansion/key-mix word to the 32-bit pre-permutation word.
- Processes LANES S-boxes per cycle, so one design covers both area-lean iterative round engines and fast round engines.
- Sits between the key-XOR stage and the P-permutation in the DES round datapath.

Parameters:
- LANES, 2, S-boxes evaluated per cycle; legal values 1, 2, 4, 8; any other value is an elaboration error.
- NGRP, 8/LANES (derived, localparam), number of RUN cycles per block.

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  unit can accept a word
- in_data  in  48  S-box inputs; in_data[47:42] feeds S1, ..., in_data[5:0] feeds S8; bit 5 of each chunk is DES b1
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- out_data  out  32  out_data[31:28] from S1, ..., out_data[3:0] from S8
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset (async, while rst=1): state=IDLE, grp=0, in_ready=1, out_valid=0, busy=0, out_data=0, captured input=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture in_data into src_reg, clear res_reg, set grp=0, go to RUN.
  - RUN: in_ready=0. Each cycle, S-boxes s = grp*LANES .. grp*LANES+LANES-1 are looked up from src_reg and their nibbles written into res_reg; grp increments. After the group with grp=NGRP-1, go to DONE.
  - DONE: out_valid=1, out_data=res_reg, held stable. On out_ready, go to IDLE and deassert out_valid.
- Lookup per S-box: chunk c[5:0] with c[5]=b1. row={c[5],c[0]}, col=c[4:1]. Output is the standard FIPS 46-3 table entry.
- Latency: a word accepted at edge T0 has out_valid=1 after edge T0+NGRP.
  - LANES=8: 1 cycle. LANES=1: 8 cycles.
- Throughput with out_ready tied high: one word per NGRP+2 cycles.
- Input capture: in_data is sampled only at acceptance; later changes are ignored.
- Backpressure: out_valid/out_data hold indefinitely while out_ready=0. in_ready stays 0 until the DONE handshake completes.
- in_valid during RUN/DONE: ignored; the word is not consumed.
- Simultaneous out_ready in DONE and in_valid: the output handshake completes and the unit enters IDLE. The new word is accepted on the following cycle; no same-cycle re-accept.
- rst asserted mid-RUN or in DONE: immediate return to the reset values; the partial result is discarded and no out_valid pulse occurs.
- No X propagation: unwritten res_reg nibbles read as 0 and are never visible, since out_valid is asserted only after all groups are written.

Decomposition:
- des_sbox_pkg:
  - constant array SBOX[0:7][0:63] of 4-bit values, indexed by {row,col}
  - FSM state enum {IDLE, RUN, DONE}
  - function for legal LANES
- Sub-module des_sbox_rom: combinational, inputs sel[2:0] and addr[5:0], output dout[3:0]; performs the row/col remap and the table read.
  - LANES instances of des_sbox_rom are generated, each driven by a mux of src_reg chunks keyed by grp.

Test Plan:
- All-zero input, LANES=2, out_ready=1: in_data=48'h0 → out_data=32'hEFA72C4D, out_valid rises exactly 4 cycles after acceptance, in_ready low throughout.
- All-ones input, each LANES in {1,2,4,8}: in_data=48'hFFFFFFFFFFFF → out_data=32'hD9CE3DCB, latency 8/4/2/1 cycles respectively.
- S7 row select: in_data chunk 7 = 6'b000001 (in_data=48'h000000000040), other chunks 0 → out_data=32'hEFA72CDD (S7 row1 col0 = 13).
- Backpressure: hold out_ready=0 for 10 cycles in DONE, toggling in_data and in_valid → out_data stable, no second acceptance. Release out_ready → out_valid drops next cycle and in_ready=1.
- Reset mid-RUN, LANES=1: assert rst at the 3rd RUN cycle → outputs return to reset values asynchronously. The next all-zero word yields 32'hEFA72C4D with no stale nibbles.
- Random 10k words, all LANES values, random valid/ready → scoreboard against a reference model of the FIPS tables; zero mismatches, no dropped or duplicated words.
